// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and op-class helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_DIV   = 3'd6,
    OP_DIVU  = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  // Even encodings are the signed variants.
  function automatic logic is_signed(input muldiv_op_t o);
    return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_DIV);
  endfunction

  function automatic logic is_acc(input muldiv_op_t o);
    return (o == OP_MADD) || (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input muldiv_op_t o);
    return (o == OP_MSUB) || (o == OP_MSUBU);
  endfunction

  function automatic logic is_div(input muldiv_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Unsigned radix-2 restoring divider datapath, one quotient bit per enabled step.
// The parent owns sequencing and sign handling.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem
);

  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_fit;

  // The dividend shifts out of the quotient register into the partial remainder
  // while quotient bits shift in from the bottom.
  assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_fit    = ~w_diff[DATA_W];

  // Load operands on accept, then one subtract-compare step per enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      if (w_fit) begin
        r_rem <= w_diff[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_rem_sh[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit producing a {HI,LO} result through a
// start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last committed result
// MUL   | product moving through MUL_STAGES retiming registers
// ACC   | add/subtract product to forwarded hilo_in
// DIV   | one restoring-divide step per cycle, DATA_W cycles
// DONE  | result presented with done, committed at end of cycle
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic [2*DATA_W-1:0] hilo_in,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic                div_by_zero
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2((DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES) + 1;

  muldiv_state_t     r_state;
  muldiv_op_t        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dbz;
  logic [PW-1:0]     r_pipe [MUL_STAGES];
  logic [PW-1:0]     r_acc;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  muldiv_op_t        w_op_in;
  logic              w_accept;
  logic              w_in_a_neg;
  logic              w_in_b_neg;
  logic [DATA_W-1:0] w_in_a_mag;
  logic [DATA_W-1:0] w_in_b_mag;
  logic              w_in_dbz;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [PW-1:0]     w_prod_mag;
  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     w_mul_p;
  logic [DATA_W-1:0] w_div_quo;
  logic [DATA_W-1:0] w_div_rem;
  logic [DATA_W-1:0] w_div_lo;
  logic [DATA_W-1:0] w_div_hi;
  logic [PW-1:0]     w_result;
  logic              w_commit;
  logic              w_div_load;
  logic              w_div_step;

  assign w_op_in    = muldiv_op_t'(op);
  assign w_accept   = (r_state == ST_IDLE) && start && !cancel;
  assign w_in_dbz   = is_div(w_op_in) && (op_b == '0);

  // Divider magnitudes come straight from the ports so stepping starts in cycle 1.
  assign w_in_a_neg = is_signed(w_op_in) && op_a[DATA_W-1];
  assign w_in_b_neg = is_signed(w_op_in) && op_b[DATA_W-1];
  assign w_in_a_mag = w_in_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_in_b_mag = w_in_b_neg ? (~op_b + 1'b1) : op_b;

  // Everything after accept works from the latched operands only.
  assign w_a_neg    = is_signed(r_op) && r_a[DATA_W-1];
  assign w_b_neg    = is_signed(r_op) && r_b[DATA_W-1];
  assign w_a_mag    = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_mag    = w_b_neg ? (~r_b + 1'b1) : r_b;
  assign w_prod_mag = {{DATA_W{1'b0}}, w_a_mag} * {{DATA_W{1'b0}}, w_b_mag};
  assign w_prod     = (w_a_neg ^ w_b_neg) ? (~w_prod_mag + 1'b1) : w_prod_mag;
  assign w_mul_p    = r_pipe[MUL_STAGES-1];

  assign w_div_load = w_accept && is_div(w_op_in) && !w_in_dbz;
  assign w_div_step = (r_state == ST_DIV);

  muldiv_div_iter #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_in_a_mag),
    .i_divisor  (w_in_b_mag),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem)
  );

  // Quotient takes the XOR of operand signs, remainder follows the dividend.
  assign w_div_lo = (w_a_neg ^ w_b_neg) ? (~w_div_quo + 1'b1) : w_div_quo;
  assign w_div_hi = w_a_neg ? (~w_div_rem + 1'b1) : w_div_rem;

  // Select the finished result for the DONE cycle according to the latched op.
  always_comb begin
    w_result = w_mul_p;
    if (r_dbz) begin
      w_result = {r_a, {DATA_W{1'b1}}};
    end else if (is_div(r_op)) begin
      w_result = {w_div_hi, w_div_lo};
    end else if (is_acc(r_op)) begin
      w_result = r_acc;
    end
  end

  // A cancel arriving in DONE must suppress the pulse and keep HI/LO, so the
  // presented result is gated by cancel and only committed if not flushed.
  assign w_commit    = (r_state == ST_DONE) && !cancel;
  assign done        = w_commit;
  assign busy        = (r_state != ST_IDLE);
  assign div_by_zero = w_commit && r_dbz;
  assign hi_out      = w_commit ? w_result[PW-1:DATA_W] : r_hi;
  assign lo_out      = w_commit ? w_result[DATA_W-1:0]  : r_lo;

  // Sequencing FSM: accept, multiply pipeline, accumulate, divide, commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (cancel && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= w_op_in;
            r_a   <= op_a;
            r_b   <= op_b;
            r_dbz <= w_in_dbz;
            if (w_in_dbz) begin
              r_state <= ST_DONE;
            end else if (is_div(w_op_in)) begin
              r_cnt   <= CNT_W'(DATA_W - 1);
              r_state <= ST_DIV;
            end else begin
              r_cnt   <= CNT_W'(MUL_STAGES - 1);
              r_state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          r_pipe[0] <= w_prod;
          for (int i = 1; i < MUL_STAGES; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
          if (r_cnt == '0) begin
            r_state <= is_acc(r_op) ? ST_ACC : ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_ACC: begin
          r_acc   <= is_sub(r_op) ? (hilo_in - w_mul_p) : (hilo_in + w_mul_p);
          r_state <= ST_DONE;
        end
        ST_DIV: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_hi    <= w_result[PW-1:DATA_W];
          r_lo    <= w_result[DATA_W-1:0];
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multi-cycle multiply/accumulate/divide unit for the EX stage. It replaces the single-cycle multiply and ad-hoc two-pass MADD/MSUB sequencing with one state machine. That machine covers MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU and produces a 2×DATA_W HI/LO result through a start/busy/done handshake. EX stalls on `busy`, and the result goes to the HI/LO write path on `done`.

## Interface
- `DATA_W`, 32: operand width; HI/LO are each DATA_W.
- `MUL_STAGES`, 2: multiplier product pipeline depth, ≥1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request; accepted only in IDLE.
- `op` in 3: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU.
- `op_a` in DATA_W: multiplicand / dividend.
- `op_b` in DATA_W: multiplier / divisor.
- `hilo_in` in 2×DATA_W: forwarded {HI,LO} accumulate source.
- `cancel` in 1: pipeline flush; abort current op.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle result-valid pulse.
- `hi_out` out DATA_W: HI result (product high / remainder).
- `lo_out` out DATA_W: LO result (product low / quotient).
- `div_by_zero` out 1: pulses with `done` when DIV/DIVU had op_b==0.

## Operation
- States: IDLE, MUL, ACC, DIV, DONE.
- IDLE + start & !cancel:
  - latch op, op_a, op_b.
  - If divide with op_b==0, go to DONE.
  - Else if divide, go to DIV.
  - Else go to MUL.
- MUL:
  - Signed ops take |a|, |b|, form the unsigned product, and negate it if sign(a)^sign(b).
  - Counter runs MUL_STAGES cycles.
  - Exit to ACC for MADD*/MSUB*, otherwise to DONE.
- ACC (one cycle):
  - Sample hilo_in in this cycle.
  - Result = hilo_in + P for MADD*, hilo_in − P for MSUB*, mod 2^(2·DATA_W).
  - Go to DONE.
- DIV:
  - Radix-2 restoring division on magnitudes, one quotient bit per cycle, DATA_W cycles.
  - Then go to DONE.
  - Signed fix-up is applied when loading the outputs: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
- Signed MIN/−1 → LO=MIN (wraps), HI=0.
- Divide by zero → LO=all ones, HI=op_a, div_by_zero=1.
- DONE:
  - Assert done for one cycle.
  - Load hi_out/lo_out.
  - Go to IDLE.
- hi_out/lo_out hold their value until the next done.
- cancel in any non-IDLE state, including DONE: IDLE next cycle, no done, hi_out/lo_out unchanged.
- cancel with start in the same cycle: cancel wins, start is dropped.
- start while busy: ignored.

## Timing
- Reset values: state IDLE; busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0; counters 0.
- Accept cycle is cycle 0. done is high in cycle N:
  - MULT/MULTU: N = MUL_STAGES+1.
  - MADD*/MSUB*: N = MUL_STAGES+2.
  - DIV/DIVU: N = DATA_W+1.
  - Divide by zero: N = 1.
- busy is high in cycles 1..N inclusive and low in cycle N+1.
- A new start is accepted in cycle N+1; back-to-back throughput is one op per N+1 cycles.
- Reset asserted mid-operation: all state and outputs return to reset values on the next edge; no done.
- The operand registers are the only inputs sampled after accept; op_a/op_b may change freely from cycle 1 on.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding enum (`muldiv_op_t`);
  - the FSM state enum;
  - the helpers `is_signed(op)`, `is_acc(op)`, `is_sub(op)`, `is_div(op)`.
- Sub-module `muldiv_div_iter`:
  - DATA_W-parametrised restoring-divider datapath (remainder/quotient shift registers, subtract-compare);
  - stepped by the parent FSM's enable;
  - unsigned only; signs handled in the parent.
- The multiplier is behavioural `*` followed by MUL_STAGES retiming registers, kept in the parent.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3, MUL_STAGES=2 → done in cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MADDU a=0xFFFFFFFF, b=2, hilo_in={0x1,0xFFFFFFFF} → done in cycle 4; HI=0x3, LO=0xFFFFFFFD.
- MSUB a=3, b=4, hilo_in={0,5} → HI=0xFFFFFFFF, LO=0xFFFFFFF9.
- DIV −7/2 → done in cycle 33; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/0 → done in cycle 1, div_by_zero=1, LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU with cancel at cycle 10 → busy=0 in cycle 11, no done, hi_out/lo_out keep prior values. A start in the same cycle as cancel is dropped. A start in cycle N+1 after a completed op is accepted. Reset pulled in cycle 5 of a DIV → outputs zero, no done.
